// File: rtl/pipe_sequencer_if.sv
// Command/status bundle between a pipeline controller and pipe_sequencer.
// The slave modport is the sequencer's view; master is the controller's view.
interface pipe_sequencer_if #(
  parameter int NB_REG = 32
);
  logic [1:0]        i_cmd;
  logic              i_cmd_valid;
  logic              i_stop;
  logic              i_halt;
  logic              o_cmd_ready;
  logic              o_valid;
  logic              o_pipe_reset;
  logic              o_done;
  logic              o_timeout;
  logic [NB_REG-1:0] o_n_clocks;
  logic [2:0]        o_state;

  modport slave (
    input  i_cmd, i_cmd_valid, i_stop, i_halt,
    output o_cmd_ready, o_valid, o_pipe_reset, o_done, o_timeout, o_n_clocks, o_state
  );

  modport master (
    output i_cmd, i_cmd_valid, i_stop, i_halt,
    input  o_cmd_ready, o_valid, o_pipe_reset, o_done, o_timeout, o_n_clocks, o_state
  );
endinterface

// File: rtl/pipe_sequencer.sv
// Run/step/drain sequencer producing the pipeline advance enable and cycle count.
// Optional macro PIPE_SEQUENCER_CYCLE_LIMIT_EN: halt RUN with a timeout after MAX_CYCLES.
module pipe_sequencer #(
  parameter int NB_REG     = 32,
  parameter int N_DRAIN    = 4,
  parameter int MAX_CYCLES = 1024
) (
  input  logic               i_clock,
  input  logic               i_reset,
  pipe_sequencer_if.slave    bus
);
  localparam int DW = (N_DRAIN < 2) ? 1 : $clog2(N_DRAIN);

  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_PRST = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4,
    S_PRST   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [NB_REG-1:0] cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic              pipe_reset_q;
  logic              enabled;

  assign enabled = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_DRAIN);

`ifndef PIPE_SEQUENCER_CYCLE_LIMIT_EN
  logic unused_max_cycles;
  assign unused_max_cycles = (MAX_CYCLES != 0);
`endif

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    if (enabled && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.i_cmd_valid) begin
          case (bus.i_cmd)
            CMD_RUN:  state_d = S_RUN;
            CMD_STEP: state_d = S_STEP;
            CMD_PRST: state_d = S_PRST;
            default:  state_d = S_IDLE;
          endcase
        end
      end
      S_RUN: begin
        // Stop wins over halt; halt wins over the cycle limit.
        if (bus.i_stop) begin
          state_d = S_IDLE;
        end else if (bus.i_halt) begin
          state_d = S_DRAIN;
          drain_d = DW'(N_DRAIN - 1);
        end
`ifdef PIPE_SEQUENCER_CYCLE_LIMIT_EN
        else if (cnt_q == NB_REG'(MAX_CYCLES - 1)) begin
          state_d   = S_HALTED;
          timeout_d = 1'b1;
        end
`endif
      end
      S_STEP: begin
        if (bus.i_halt) begin
          state_d = S_DRAIN;
          drain_d = DW'(N_DRAIN - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_HALTED;
        else               drain_d = drain_q - 1'b1;
      end
      S_HALTED: begin
        if (bus.i_cmd_valid && (bus.i_cmd == CMD_PRST)) state_d = S_PRST;
      end
      S_PRST:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Clearing on entry makes the counters read zero during the PRST cycle itself.
    if (state_d == S_PRST) begin
      cnt_d     = '0;
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      drain_q      <= '0;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
      pipe_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
      pipe_reset_q <= (state_d == S_PRST);
    end
  end

  assign bus.o_cmd_ready  = (state_q == S_IDLE) || (state_q == S_HALTED);
  assign bus.o_valid      = enabled;
  assign bus.o_pipe_reset = pipe_reset_q;
  assign bus.o_done       = (state_q == S_HALTED) && !timeout_q;
  assign bus.o_n_clocks   = cnt_q;
  assign bus.o_state      = state_q;
`ifdef PIPE_SEQUENCER_CYCLE_LIMIT_EN
  assign bus.o_timeout    = timeout_q;
`else
  assign bus.o_timeout    = 1'b0;
`endif
endmodule

// File: doc/pipe_sequencer.md
PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

Interface
REQ-001 Parameter NB_REG, default 32, is the width of the cycle counter.
REQ-002 Parameter N_DRAIN, default 4, is the number of enabled cycles issued after a halt is detected.
REQ-003 Parameter MAX_CYCLES, default 1024, is the cycle limit used only when CYCLE_LIMIT_EN is defined.
REQ-004 i_clock  in  1  the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_cmd  in  2  command code: 00 NOP, 01 RUN, 10 STEP, 11 PRST (pipeline reset).
REQ-007 i_cmd_valid  in  1  a command is presented.
REQ-008 i_stop  in  1  abort request while in RUN.
REQ-009 i_halt  in  1  the decode stage has decoded a HALT instruction.
REQ-010 o_cmd_ready  out  1  a command can be accepted this cycle.
REQ-011 o_valid  out  1  pipeline advance enable, driving the pipeline i_valid.
REQ-012 o_pipe_reset  out  1  one-cycle pipeline reset pulse.
REQ-013 o_done  out  1  the program has drained after a HALT.
REQ-014 o_timeout  out  1  the cycle limit was hit.
REQ-015 o_n_clocks  out  NB_REG  count of enabled cycles.
REQ-016 o_state  out  3  state encoding: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4, PRST=5.

Function
REQ-017 A command SHALL be accepted only on a cycle where i_cmd_valid=1 and o_cmd_ready=1.
REQ-018 o_cmd_ready SHALL be 1 exactly when the state is IDLE or HALTED.
REQ-019 In IDLE, an accepted command SHALL cause the following transition on the next cycle: RUN to RUN, STEP to STEP, PRST to PRST, and NOP leaves the state IDLE.
REQ-020 In HALTED, only PRST SHALL change state (to PRST); RUN, STEP and NOP SHALL be accepted and ignored.
REQ-021 o_valid SHALL be 1 exactly in the states RUN, STEP and DRAIN, and 0 otherwise.
REQ-022 In STEP, the block SHALL hold o_valid=1 for exactly one cycle and then return to IDLE, unless REQ-024 applies.
REQ-023 In RUN, i_stop=1 SHALL move the state to IDLE on the next cycle, taking precedence over i_halt in the same cycle.
REQ-024 In RUN or STEP, i_halt=1 SHALL move the state to DRAIN and load a drain counter with N_DRAIN-1.
REQ-025 In DRAIN, the drain counter SHALL decrement every cycle, and the state SHALL move to HALTED in the cycle after the counter reads 0, giving exactly N_DRAIN cycles with o_valid=1.
REQ-026 In DRAIN, both i_stop and i_halt SHALL be ignored.
REQ-027 o_done SHALL be 1 exactly while the state is HALTED with o_timeout=0.
REQ-028 PRST SHALL last exactly one cycle, with o_pipe_reset=1, o_n_clocks cleared to 0, o_timeout cleared to 0, and a next state of IDLE.
REQ-029 o_n_clocks SHALL increment by 1 on every cycle where o_valid=1.
REQ-030 o_n_clocks SHALL saturate at all-ones and never wrap around.
REQ-031 All outputs SHALL be registered or decoded from registered state only, with no combinational path from any input to any output.

Reset
REQ-032 While i_reset=1, the state SHALL be IDLE, o_valid=0, o_pipe_reset=1, o_done=0, o_timeout=0, o_n_clocks=0, and the drain counter=0.
REQ-033 i_reset SHALL override any state, including RUN mid-operation, and the cycle after reset deasserts SHALL be IDLE with o_pipe_reset=0.

Configuration
REQ-034 When the macro PIPE_SEQUENCER_CYCLE_LIMIT_EN is defined, an enabled cycle in RUN with o_n_clocks=MAX_CYCLES-1 SHALL move the state to HALTED and set o_timeout=1, which holds until PRST or reset.
REQ-035 When PIPE_SEQUENCER_CYCLE_LIMIT_EN is defined, a simultaneous i_halt SHALL take precedence over the limit, so that DRAIN is entered and no timeout occurs.
REQ-036 When PIPE_SEQUENCER_CYCLE_LIMIT_EN is undefined, o_timeout SHALL be constant 0 and RUN SHALL have no cycle limit.

Verification
REQ-037 Bench scenario: after reset, issue STEP 3 times -> exactly 3 one-cycle o_valid pulses, o_n_clocks=3, and the state returns to IDLE each time.
REQ-038 Bench scenario: RUN, then i_halt on the 10th enabled cycle with N_DRAIN=4 -> 14 o_valid cycles in total, o_n_clocks=14, then HALTED with o_done=1.
REQ-039 Bench scenario: RUN, then i_stop and i_halt in the same cycle -> IDLE on the next cycle and no DRAIN.
REQ-040 Bench scenario: in HALTED, issue RUN -> accepted and ignored; then issue PRST -> one o_pipe_reset pulse, o_n_clocks=0, and IDLE.
REQ-041 Bench scenario: i_reset asserted during DRAIN -> IDLE, o_valid=0, o_n_clocks=0, and o_pipe_reset=1 while reset is high.
REQ-042 Bench scenario: with PIPE_SEQUENCER_CYCLE_LIMIT_EN defined and MAX_CYCLES=16, RUN with no halt -> exactly 16 o_valid cycles, then HALTED with o_timeout=1 and o_done=0.
